// File: rtl/ow_pkg.sv
// ow_pkg -- shared definitions for the one-wire master controller.
//   Command op encodings, FSM state encoding, default bus timings
//   (1 clk cycle = 1 us) and the serial Dallas CRC-8 step.
package ow_pkg;

  typedef enum logic [1:0] {
    OP_RESET = 2'b00,
    OP_WRITE = 2'b01,
    OP_READ  = 2'b10,
    OP_RSVD  = 2'b11
  } ow_op_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RST_LOW  = 3'd1,
    ST_RST_REL  = 3'd2,
    ST_SLOT_LOW = 3'd3,
    ST_SLOT_REL = 3'd4,
    ST_SLOT_REC = 3'd5,
    ST_DONE     = 3'd6
  } ow_state_e;

  localparam int unsigned T_RSTL_DEF  = 480;
  localparam int unsigned T_PDS_DEF   = 70;
  localparam int unsigned T_RSTH_DEF  = 480;
  localparam int unsigned T_SLOT_DEF  = 70;
  localparam int unsigned T_LOW1_DEF  = 6;
  localparam int unsigned T_LOW0_DEF  = 60;
  localparam int unsigned T_RDSMP_DEF = 15;
  localparam int unsigned T_REC_DEF   = 10;

  // Reflected form of x^8+x^5+x^4+1, shifted LSB first.
  localparam logic [7:0] CRC8_POLY_REFL = 8'h8C;

  function automatic logic [7:0] crc8_step(input logic [7:0] crc_in, input logic b);
    logic fb;
    fb = crc_in[0] ^ b;
    crc8_step = {1'b0, crc_in[7:1]} ^ (fb ? CRC8_POLY_REFL : 8'h00);
  endfunction

endpackage

// File: rtl/ow_crc8.sv
// ow_crc8 -- 1-bit serial Dallas CRC-8 accumulator.
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset (crc -> 0x00)
//   clr_i  : synchronous clear to 0x00 (wins over en_i)
//   en_i   : fold bit_i into the CRC this cycle
//   bit_i  : data bit, presented LSB first
//   crc_o  : current CRC value
module ow_crc8
  import ow_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic       bit_i,
  output logic [7:0] crc_o
);

  logic [7:0] crc_q;
  logic [7:0] crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clr_i) begin
      crc_d = 8'h00;
    end else if (en_i) begin
      crc_d = crc8_step(crc_q, bit_i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q <= 8'h00;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/ow_master_ctrl.sv
// ow_master_ctrl -- one-wire bus master: reset/presence, byte write, byte read.
//   clk, reset_n           : clock (rising edge), asynchronous active-low reset
//   cmd_valid/cmd_ready    : command handshake, ready only while idle
//   cmd_op, cmd_data       : 00 RESET, 01 WRITE_BYTE, 10 READ_BYTE, 11 reserved; write byte
//   rsp_valid              : one-cycle completion pulse
//   rsp_data               : last byte read (changed only by READ_BYTE)
//   rsp_presence, rsp_err  : presence seen at last RESET; error flag of last command
//   bus_in, bus_drive_low  : raw bus level; open-drain pull-low enable
//   busy, crc              : not idle; running CRC-8
// Build option: define OW_MASTER_CRC8_EN to accumulate Dallas CRC-8 over every
// bit moved on the bus (cleared by RESET); otherwise crc is constant 0x00.
module ow_master_ctrl
  import ow_pkg::*;
#(
  parameter int unsigned T_RSTL  = T_RSTL_DEF,
  parameter int unsigned T_PDS   = T_PDS_DEF,
  parameter int unsigned T_RSTH  = T_RSTH_DEF,
  parameter int unsigned T_SLOT  = T_SLOT_DEF,
  parameter int unsigned T_LOW1  = T_LOW1_DEF,
  parameter int unsigned T_LOW0  = T_LOW0_DEF,
  parameter int unsigned T_RDSMP = T_RDSMP_DEF,
  parameter int unsigned T_REC   = T_REC_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_presence,
  output logic       rsp_err,
  input  logic       bus_in,
  output logic       bus_drive_low,
  output logic       busy,
  output logic [7:0] crc
);

  localparam int unsigned TMAX_A = (T_RSTL > T_RSTH) ? T_RSTL : T_RSTH;
  localparam int unsigned TMAX_B = (T_SLOT > T_REC) ? T_SLOT : T_REC;
  localparam int unsigned TMAX   = (TMAX_A > TMAX_B) ? TMAX_A : TMAX_B;
  localparam int unsigned TW     = $clog2(TMAX + 1);

  ow_state_e     state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  ow_op_e        op_q, op_d;
  logic [7:0]    sh_q, sh_d;
  logic          pres_q, pres_d;
  logic [7:0]    rsp_data_q, rsp_data_d;
  logic          rsp_pres_q, rsp_pres_d;
  logic          rsp_err_q, rsp_err_d;
  logic [1:0]    sync_q;
  logic          sync_bus;
  logic [TW-1:0] low_last;

  assign sync_bus = sync_q[1];

  // Low phase of a slot: long only when writing a 0 bit.
  assign low_last = (op_q == OP_WRITE && !sh_q[0]) ? TW'(T_LOW0 - 1) : TW'(T_LOW1 - 1);

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q + TW'(1);
    bitcnt_d      = bitcnt_q;
    op_d          = op_q;
    sh_d          = sh_q;
    pres_d        = pres_q;
    rsp_data_d    = rsp_data_q;
    rsp_pres_d    = rsp_pres_q;
    rsp_err_d     = rsp_err_q;
    cmd_ready     = 1'b0;
    bus_drive_low = 1'b0;
    rsp_valid     = 1'b0;
    busy          = 1'b1;
    case (state_q)
      ST_IDLE: begin
        busy      = 1'b0;
        cmd_ready = 1'b1;
        timer_d   = '0;
        if (cmd_valid) begin
          op_d     = ow_op_e'(cmd_op);
          sh_d     = cmd_data;
          bitcnt_d = '0;
          case (ow_op_e'(cmd_op))
            OP_RESET: begin
              state_d = ST_RST_LOW;
              pres_d  = 1'b0;
            end
            OP_WRITE, OP_READ: state_d = ST_SLOT_LOW;
            default: begin
              state_d   = ST_DONE;
              rsp_err_d = 1'b1;
            end
          endcase
        end
      end
      ST_RST_LOW: begin
        bus_drive_low = 1'b1;
        if (timer_q == TW'(T_RSTL - 1)) begin
          state_d = ST_RST_REL;
          timer_d = '0;
        end
      end
      ST_RST_REL: begin
        if (timer_q == TW'(T_PDS)) pres_d = !sync_bus;
        if (timer_q == TW'(T_RSTH - 1)) begin
          state_d    = ST_DONE;
          timer_d    = '0;
          rsp_pres_d = (timer_q == TW'(T_PDS)) ? !sync_bus : pres_q;
          // Bus still low at the very end of recovery: something holds it.
          rsp_err_d  = !sync_bus;
        end
      end
      ST_SLOT_LOW: begin
        bus_drive_low = 1'b1;
        if (timer_q == low_last) state_d = ST_SLOT_REL;
      end
      ST_SLOT_REL: begin
        if (op_q == OP_READ && timer_q == TW'(T_RDSMP)) sh_d = {sync_bus, sh_q[7:1]};
        if (timer_q == TW'(T_SLOT - 1)) begin
          state_d = ST_SLOT_REC;
          timer_d = '0;
        end
      end
      ST_SLOT_REC: begin
        if (timer_q == TW'(T_REC - 1)) begin
          timer_d = '0;
          // Rotate so the next write bit sits in bit 0.
          if (op_q == OP_WRITE) sh_d = {sh_q[0], sh_q[7:1]};
          if (bitcnt_q == 3'd7) begin
            state_d   = ST_DONE;
            rsp_err_d = 1'b0;
            if (op_q == OP_READ) rsp_data_d = sh_q;
          end else begin
            bitcnt_d = bitcnt_q + 3'd1;
            state_d  = ST_SLOT_LOW;
          end
        end
      end
      ST_DONE: begin
        rsp_valid = 1'b1;
        timer_d   = '0;
        state_d   = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      bitcnt_q   <= '0;
      op_q       <= OP_RESET;
      sh_q       <= 8'h00;
      pres_q     <= 1'b0;
      rsp_data_q <= 8'h00;
      rsp_pres_q <= 1'b0;
      rsp_err_q  <= 1'b0;
      sync_q     <= 2'b11;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      bitcnt_q   <= bitcnt_d;
      op_q       <= op_d;
      sh_q       <= sh_d;
      pres_q     <= pres_d;
      rsp_data_q <= rsp_data_d;
      rsp_pres_q <= rsp_pres_d;
      rsp_err_q  <= rsp_err_d;
      sync_q     <= {sync_q[0], bus_in};
    end
  end

  assign rsp_data     = rsp_data_q;
  assign rsp_presence = rsp_pres_q;
  assign rsp_err      = rsp_err_q;

`ifdef OW_MASTER_CRC8_EN
  logic crc_clr, crc_en, crc_bit;

  assign crc_clr = (state_q == ST_IDLE) && cmd_valid && (cmd_op == OP_RESET);
  // Fold each bit once, at the last released cycle of its slot: a read bit
  // has just been shifted into bit 7, a write bit still sits in bit 0.
  assign crc_en  = (state_q == ST_SLOT_REL) && (timer_q == TW'(T_SLOT - 1));
  assign crc_bit = (op_q == OP_READ) ? sh_q[7] : sh_q[0];

  ow_crc8 u_crc8 (
    .clk   (clk),
    .rst_n (reset_n),
    .clr_i (crc_clr),
    .en_i  (crc_en),
    .bit_i (crc_bit),
    .crc_o (crc)
  );
`else
  assign crc = 8'h00;
`endif

endmodule

// File: tb/tb_ow_master_ctrl.sv
module tb_ow_master_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_presence;
  logic       rsp_err;
  logic       bus_in;
  logic       bus_drive_low;
  logic       busy;
  logic [7:0] crc;

  ow_master_ctrl dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_data     (cmd_data),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .rsp_presence (rsp_presence),
    .rsp_err      (rsp_err),
    .bus_in       (bus_in),
    .bus_drive_low(bus_drive_low),
    .busy         (busy),
    .crc          (crc)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- device / bus emulation ----------------
  bit         dev_present = 1'b0;
  bit         dev_stuck   = 1'b0;
  bit         dev_read    = 1'b0;
  logic [7:0] dev_byte    = 8'h00;
  int         dev_rise    = 0;
  logic       dev_low     = 1'b0;

  assign bus_in = ~(bus_drive_low | dev_low);

  int widths[$];
  int periods[$];
  int low_cnt    = 0;
  int last_start = 0;
  int rel_start  = 0;
  bit have_start = 1'b0;
  bit rst_seen   = 1'b0;
  bit drv_prev   = 1'b0;
  bit cur_bit    = 1'b1;

  initial begin : device
    forever begin
      @(negedge clk);
      if (bus_drive_low && !drv_prev) begin
        if (have_start) periods.push_back(cyc - last_start);
        have_start = 1'b1;
        last_start = cyc;
        low_cnt    = 0;
        cur_bit    = dev_byte[dev_rise % 8];
        dev_rise++;
        rst_seen   = 1'b0;
      end
      if (bus_drive_low) low_cnt++;
      if (!bus_drive_low && drv_prev) begin
        widths.push_back(low_cnt);
        if (low_cnt >= 400) begin
          rst_seen  = 1'b1;
          rel_start = cyc;
        end
      end
      drv_prev = bus_drive_low;
      dev_low = dev_stuck
             || (dev_present && rst_seen && (cyc - rel_start) >= 60 && (cyc - rel_start) <= 180)
             || (dev_read && have_start && !rst_seen && !cur_bit && (cyc - last_start) < 30);
    end
  end

  // ---------------- checking ----------------
  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] m_data = 8'h00;
  logic [7:0] m_crc  = 8'h00;
  logic       m_pres = 1'b0;
  logic       m_err  = 1'b0;
  int         m_lat  = 0;

  function automatic logic [7:0] crc_byte(input logic [7:0] c_in, input logic [7:0] d);
    logic [7:0] c;
    c = c_in;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ d[i]) c = (c >> 1) ^ 8'h8C;
      else             c = c >> 1;
    end
    return c;
  endfunction

  function automatic logic [7:0] exp_crc();
`ifdef OW_MASTER_CRC8_EN
    return m_crc;
`else
    return 8'h00;
`endif
  endfunction

  task automatic model_cmd(input logic [1:0] op, input logic [7:0] d, input bit pres,
                           input bit stuck, input logic [7:0] dbyte);
    case (op)
      2'b00: begin m_pres = pres | stuck; m_err = stuck; m_crc = 8'h00; m_lat = 961; end
      2'b01: begin m_err = 1'b0; m_crc = crc_byte(m_crc, d); m_lat = 641; end
      2'b10: begin m_data = dbyte; m_err = 1'b0; m_crc = crc_byte(m_crc, dbyte); m_lat = 641; end
      default: begin m_err = 1'b1; m_lat = 1; end
    endcase
  endtask

  // Issue one command from a negedge; returns at the negedge showing rsp_valid.
  task automatic run_cmd(input logic [1:0] op, input logic [7:0] d, input bit poke, output int lat);
    int n;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    widths.delete();
    periods.delete();
    dev_rise   = 0;
    have_start = 1'b0;
    cmd_op    = op;
    cmd_data  = d;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 1;
    while (!rsp_valid && n < 2000) begin
      @(negedge clk);
      n++;
      if (poke && n == 100) begin cmd_valid = 1'b1; cmd_op = 2'b00; end
      else cmd_valid = 1'b0;
    end
    lat = rsp_valid ? n : -1;
  endtask

  typedef struct {
    logic [1:0] op;
    logic [7:0] data;
    bit         present;
    bit         stuck;
    bit         rd;
    logic [7:0] dbyte;
    bit         poke;
    logic [7:0] e_data;
    bit         e_pres;
    bit         e_err;
    int         e_lat;
  } vec_t;

  vec_t tbl[7];

  initial begin : watchdog
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int lat;
    int okw;
    logic [7:0] seq[8];

    tbl[0] = '{2'b00, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 961};
    tbl[1] = '{2'b01, 8'hA5, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 641};
    tbl[2] = '{2'b10, 8'h00, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 8'h3C, 1'b1, 1'b0, 641};
    tbl[3] = '{2'b11, 8'hFF, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h3C, 1'b1, 1'b1, 1};
    tbl[4] = '{2'b00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h3C, 1'b0, 1'b0, 961};
    tbl[5] = '{2'b00, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h3C, 1'b1, 1'b1, 961};
    tbl[6] = '{2'b10, 8'h00, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b1, 8'h5A, 1'b1, 1'b0, 641};

    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_data  = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_drive_low", bus_drive_low, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 8'h00);
    check("rst_presence", rsp_presence, 0);
    check("rst_err", rsp_err, 0);
    check("rst_crc", crc, 8'h00);
    check("rst_busy", busy, 0);
    check("rst_ready", cmd_ready, 1);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Table-driven directed commands.
    for (int i = 0; i < 7; i++) begin
      dev_present = tbl[i].present;
      dev_stuck   = tbl[i].stuck;
      dev_read    = tbl[i].rd;
      dev_byte    = tbl[i].dbyte;
      model_cmd(tbl[i].op, tbl[i].data, tbl[i].present, tbl[i].stuck, tbl[i].dbyte);
      run_cmd(tbl[i].op, tbl[i].data, tbl[i].poke, lat);
      check($sformatf("v%0d_latency", i), lat, tbl[i].e_lat);
      check($sformatf("v%0d_rsp_data", i), rsp_data, tbl[i].e_data);
      check($sformatf("v%0d_presence", i), rsp_presence, tbl[i].e_pres);
      check($sformatf("v%0d_err", i), rsp_err, tbl[i].e_err);
      check($sformatf("v%0d_crc", i), crc, exp_crc());
      if (tbl[i].op == 2'b00) begin
        check($sformatf("v%0d_rst_width", i), (widths.size() > 0) ? widths[0] : -1, 480);
      end
      if (tbl[i].op == 2'b01) begin
        check("wr_pulse_count", widths.size(), 8);
        check("wr_period_count", periods.size(), 7);
        if (widths.size() == 8 && periods.size() == 7) begin
          for (int b = 0; b < 8; b++)
            check($sformatf("wr_width%0d", b), widths[b], tbl[i].data[b] ? 6 : 60);
          for (int b = 0; b < 7; b++)
            check($sformatf("wr_period%0d", b), periods[b], 80);
        end
      end
      dev_stuck = 1'b0;
      @(negedge clk);
      check($sformatf("v%0d_valid_one_cycle", i), rsp_valid, 0);
      check($sformatf("v%0d_ready_after", i), cmd_ready, 1);
    end

`ifdef OW_MASTER_CRC8_EN
    // ROM-code style CRC sequence.
    seq = '{8'h02, 8'h1C, 8'hB8, 8'h01, 8'h00, 8'h00, 8'h00, 8'hA2};
    dev_present = 1'b1;
    dev_read    = 1'b0;
    model_cmd(2'b00, 8'h00, 1'b1, 1'b0, 8'h00);
    run_cmd(2'b00, 8'h00, 1'b0, lat);
    check("crc_after_reset", crc, 8'h00);
    dev_read = 1'b1;
    for (int k = 0; k < 8; k++) begin
      dev_byte = seq[k];
      model_cmd(2'b10, 8'h00, 1'b0, 1'b0, seq[k]);
      run_cmd(2'b10, 8'h00, 1'b0, lat);
      check($sformatf("crc_seq_data%0d", k), rsp_data, seq[k]);
      if (k == 6) check("crc_rom7", crc, 8'hA2);
    end
    check("crc_rom8_zero", crc, 8'h00);
`endif

    // Randomized commands against the reference model.
    for (int it = 0; it < 12; it++) begin
      int r;
      logic [1:0] op;
      logic [7:0] d;
      logic [7:0] db;
      bit pr;
      r  = $urandom_range(0, 9);
      op = (r == 0) ? 2'b00 : (r == 1) ? 2'b11 : (r < 6) ? 2'b01 : 2'b10;
      d  = 8'($urandom);
      db = 8'($urandom);
      pr = 1'($urandom_range(0, 1));
      dev_present = pr;
      dev_stuck   = 1'b0;
      dev_read    = (op == 2'b10);
      dev_byte    = db;
      model_cmd(op, d, pr, 1'b0, db);
      run_cmd(op, d, 1'b0, lat);
      check($sformatf("rnd%0d_latency", it), lat, m_lat);
      check($sformatf("rnd%0d_rsp_data", it), rsp_data, m_data);
      check($sformatf("rnd%0d_presence", it), rsp_presence, m_pres);
      check($sformatf("rnd%0d_err", it), rsp_err, m_err);
      check($sformatf("rnd%0d_crc", it), crc, exp_crc());
      if (op == 2'b01) begin
        okw = (widths.size() == 8) ? 1 : 0;
        if (okw == 1)
          for (int b = 0; b < 8; b++) if (widths[b] != (d[b] ? 6 : 60)) okw = 0;
        check($sformatf("rnd%0d_wr_widths", it), okw, 1);
      end
    end

    // Reset asserted in the middle of a write-0 slot.
    dev_read = 1'b0;
    dev_present = 1'b0;
    @(negedge clk);
    while (!cmd_ready) @(negedge clk);
    cmd_op    = 2'b01;
    cmd_data  = 8'h00;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (20) @(negedge clk);
    check("mid_driving_before", bus_drive_low, 1);
    reset_n = 1'b0;
    #1;
    check("mid_release_async", bus_drive_low, 0);
    check("mid_busy_cleared", busy, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    m_data = 8'h00; m_pres = 1'b0; m_err = 1'b0; m_crc = 8'h00;
    okw = 0;
    for (int k = 0; k < 700; k++) begin
      @(negedge clk);
      if (rsp_valid) okw++;
    end
    check("mid_no_rsp_valid", okw, 0);
    check("mid_ready", cmd_ready, 1);
    check("mid_rsp_data", rsp_data, m_data);
    check("mid_presence", rsp_presence, m_pres);
    check("mid_crc", crc, exp_crc());

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
